// File: rtl/ones4_pad_tx.sv
// ones4_pad_tx: 2-bit symbol framer that pads each frame so its total 1-count is 0 mod 4.
// Optional completed-frame counter port frame_cnt enabled by defining ONES4_FRAME_CNT_EN.
module ones4_pad_tx #(
  parameter bit FORCE_TRAILER = 1'b0,
  parameter int FRAME_CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [1:0]             out_data,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic                   busy
`ifdef ONES4_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);
  typedef enum logic [1:0] {PASS, PAD_A, PAD_B} state_t;
  state_t     state_q, state_d;
  logic [1:0] rem_q, rem_d, data_q, data_d, r;
  logic       valid_q, valid_d, last_q, last_d, out_free;
  function automatic logic [1:0] pc(input logic [1:0] s);
    return {s[1] & s[0], s[1] ^ s[0]};
  endfunction
  assign out_free  = !valid_q || out_ready;
  assign in_ready  = (state_q == PASS) && out_free;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = (state_q != PASS) || (rem_q != 2'd0) || (valid_q && !last_q);
  assign r         = rem_q + pc(in_data);
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q && !out_ready;
    if (state_q == PASS && in_valid && out_free) begin
      data_d  = in_data;
      valid_d = 1'b1;
      last_d  = in_last && (r == 2'd0) && !FORCE_TRAILER;
      rem_d   = r;
      state_d = (in_last && !last_d) ? PAD_A : PASS;
    end else if (state_q == PAD_A && out_free) begin
      // rem=1 needs 3 more ones: 11 now, 01 from PAD_B
      valid_d = 1'b1;
      data_d  = (rem_q == 2'd1 || rem_q == 2'd2) ? 2'b11 : (rem_q == 2'd3) ? 2'b01 : 2'b00;
      last_d  = rem_q != 2'd1;
      rem_d   = {1'b0, rem_q == 2'd1};
      state_d = (rem_q == 2'd1) ? PAD_B : PASS;
    end else if (state_q == PAD_B && out_free) begin
      valid_d = 1'b1;
      data_d  = 2'b01;
      last_d  = 1'b1;
      rem_d   = 2'd0;
      state_d = PASS;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PASS;
      rem_q   <= 2'd0;
      data_q  <= 2'b00;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end
`ifdef ONES4_FRAME_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_cnt <= '0;
    else if (valid_q && out_ready && last_q) frame_cnt <= frame_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_ones4_pad_tx.sv
// tb_ones4_pad_tx: table vectors, hand sequences and a queue-based random model for ones4_pad_tx.
module tb_ones4_pad_tx;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic       in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [1:0] in_data = 2'b00;
  logic       in_ready, out_valid, out_last, busy;
  logic [1:0] out_data;
  logic       f_in_valid = 1'b0, f_in_last = 1'b0, f_out_ready = 1'b1;
  logic [1:0] f_in_data = 2'b00;
  logic       f_in_ready, f_out_valid, f_out_last, f_busy;
  logic [1:0] f_out_data;
`ifdef ONES4_FRAME_CNT_EN
  logic [15:0] frame_cnt, f_frame_cnt;
`endif
  ones4_pad_tx #(.FORCE_TRAILER(1'b0), .FRAME_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .busy(busy)
`ifdef ONES4_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );
  ones4_pad_tx #(.FORCE_TRAILER(1'b1), .FRAME_CNT_W(16)) dut_ft (
    .clk(clk), .rst(rst), .in_data(f_in_data), .in_valid(f_in_valid), .in_last(f_in_last),
    .in_ready(f_in_ready), .out_data(f_out_data), .out_valid(f_out_valid), .out_last(f_out_last),
    .out_ready(f_out_ready), .busy(f_busy)
`ifdef ONES4_FRAME_CNT_EN
    , .frame_cnt(f_frame_cnt)
`endif
  );
  int nvec = 0, nerr = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  typedef struct {
    logic v; logic [1:0] d; logic l; logic r;
    logic eov; logic [1:0] ed; logic el; logic eir; logic eb;
  } vec_t;
  function automatic vec_t mk(input logic v, input logic [1:0] d, input logic l, input logic r,
                              input logic eov, input logic [1:0] ed, input logic el,
                              input logic eir, input logic eb);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.r = r; t.eov = eov; t.ed = ed; t.el = el; t.eir = eir; t.eb = eb;
    return t;
  endfunction
  vec_t tbl[19];
  logic [2:0] q[$];
  logic [1:0] run;
  int         mcnt, tot, need;
  logic       eir;
  initial begin
    // frame 01,10,11L; frame 11,10L (one pad); frame 01L (two pads); backpressure frame
    tbl[0]  = mk(1, 2'b01, 0, 1,  0, 2'b00, 0, 1, 0);
    tbl[1]  = mk(1, 2'b10, 0, 1,  1, 2'b01, 0, 1, 1);
    tbl[2]  = mk(1, 2'b11, 1, 1,  1, 2'b10, 0, 1, 1);
    tbl[3]  = mk(1, 2'b11, 0, 1,  1, 2'b11, 1, 1, 0);
    tbl[4]  = mk(1, 2'b10, 1, 1,  1, 2'b11, 0, 1, 1);
    tbl[5]  = mk(1, 2'b01, 1, 1,  1, 2'b10, 0, 0, 1);
    tbl[6]  = mk(1, 2'b01, 1, 1,  1, 2'b01, 1, 1, 0);
    tbl[7]  = mk(0, 2'b00, 0, 1,  1, 2'b01, 0, 0, 1);
    tbl[8]  = mk(0, 2'b00, 0, 1,  1, 2'b11, 0, 0, 1);
    tbl[9]  = mk(0, 2'b00, 0, 1,  1, 2'b01, 1, 1, 0);
    tbl[10] = mk(0, 2'b00, 0, 1,  0, 2'b01, 1, 1, 0);
    tbl[11] = mk(1, 2'b11, 0, 1,  0, 2'b01, 1, 1, 0);
    tbl[12] = mk(1, 2'b01, 0, 0,  1, 2'b11, 0, 0, 1);
    tbl[13] = mk(1, 2'b01, 0, 0,  1, 2'b11, 0, 0, 1);
    tbl[14] = mk(1, 2'b01, 0, 0,  1, 2'b11, 0, 0, 1);
    tbl[15] = mk(1, 2'b01, 0, 1,  1, 2'b11, 0, 1, 1);
    tbl[16] = mk(1, 2'b01, 1, 1,  1, 2'b01, 0, 1, 1);
    tbl[17] = mk(0, 2'b00, 0, 1,  1, 2'b01, 1, 1, 0);
    tbl[18] = mk(0, 2'b00, 0, 1,  0, 2'b01, 1, 1, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      in_valid = tbl[i].v; in_data = tbl[i].d; in_last = tbl[i].l; out_ready = tbl[i].r;
      #1;
      chk($sformatf("tbl%0d out_valid", i), out_valid, tbl[i].eov);
      chk($sformatf("tbl%0d out_data", i), out_data, tbl[i].ed);
      chk($sformatf("tbl%0d out_last", i), out_last, tbl[i].el);
      chk($sformatf("tbl%0d in_ready", i), in_ready, tbl[i].eir);
      chk($sformatf("tbl%0d busy", i), busy, tbl[i].eb);
    end
    // async reset while in PAD_B, then a single 00 frame
    @(negedge clk);
    in_valid = 1'b1; in_data = 2'b01; in_last = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("padb out_data", out_data, 2'b11);
    chk("padb in_ready", in_ready, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst out_data", out_data, 2'b00);
    chk("rst out_last", out_last, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; in_data = 2'b00; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("z00 out_valid", out_valid, 1'b1);
    chk("z00 out_data", out_data, 2'b00);
    chk("z00 out_last", out_last, 1'b1);
    chk("z00 busy", busy, 1'b0);
    @(negedge clk);
    #1;
    chk("z00 drained", out_valid, 1'b0);
    chk("z00 in_ready", in_ready, 1'b1);
`ifdef ONES4_FRAME_CNT_EN
    chk("z00 frame_cnt", frame_cnt, 32'd1);
`endif
    // random traffic against a frame-level model: queue of {last,data} still owed on the link
    run = 2'd0; mcnt = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      in_valid = $urandom_range(0, 3) != 0;
      in_data = 2'($urandom);
      in_last = $urandom_range(0, 3) == 0;
      out_ready = $urandom_range(0, 3) != 0;
      #1;
`ifdef ONES4_FRAME_CNT_EN
      chk("rnd frame_cnt", frame_cnt, 32'(mcnt % 65536));
`endif
      eir = (q.size() == 0) || (q.size() == 1 && out_ready);
      chk("rnd out_valid", out_valid, q.size() != 0);
      chk("rnd in_ready", in_ready, eir);
      chk("rnd busy", busy, q.size() > 1 || run != 2'd0 || (q.size() > 0 && !q[0][2]));
      if (q.size() > 0 && out_ready) begin
        chk("rnd symbol", {out_last, out_data}, q[0]);
        if (q[0][2]) mcnt++;
        void'(q.pop_front());
      end
      if (in_valid && eir) begin
        tot = int'(run) + $countones(in_data);
        if (!in_last) begin
          q.push_back({1'b0, in_data});
          run = 2'(tot % 4);
        end else begin
          need = (4 - tot % 4) % 4;
          q.push_back({need == 0, in_data});
          if (need == 1) q.push_back({1'b1, 2'b01});
          if (need == 2) q.push_back({1'b1, 2'b11});
          if (need == 3) begin
            q.push_back({1'b0, 2'b11});
            q.push_back({1'b1, 2'b01});
          end
          run = 2'd0;
        end
      end
    end
    // forced trailer on a frame already at 0 mod 4
    @(negedge clk);
    f_in_valid = 1'b1; f_in_data = 2'b11; f_in_last = 1'b0;
    #1;
    chk("ft idle out_valid", f_out_valid, 1'b0);
    @(negedge clk);
    f_in_last = 1'b1;
    #1;
    chk("ft s0 out_data", f_out_data, 2'b11);
    chk("ft s0 out_last", f_out_last, 1'b0);
    @(negedge clk);
    f_in_valid = 1'b0;
    #1;
    chk("ft s1 out_data", f_out_data, 2'b11);
    chk("ft s1 out_last", f_out_last, 1'b0);
    chk("ft s1 in_ready", f_in_ready, 1'b0);
    @(negedge clk);
    #1;
    chk("ft trailer out_valid", f_out_valid, 1'b1);
    chk("ft trailer out_data", f_out_data, 2'b00);
    chk("ft trailer out_last", f_out_last, 1'b1);
    chk("ft trailer in_ready", f_in_ready, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
